// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   HI/LO multiply/divide unit fed by the register-file read operands.
//   Executes MULT/MULTU in one extra cycle and DIV/DIVU with a 32-step
//   restoring divider followed by a sign-fix cycle. MTHI/MTLO write
//   HI/LO directly while idle.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      request, sampled only while busy=0
//   op[2:0]    0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6,7 ignored)
//   operand_a  rs data (multiplicand / dividend / MTHI-MTLO source)
//   operand_b  rt data (multiplier / divisor)
//   busy       operation in flight; start ignored
//   done       one-cycle pulse after HI/LO written by a mul/div
//   hi, lo     HI and LO registers
//
// state   | meaning
// IDLE    | accepting start; MTHI/MTLO execute here
// MUL     | product written to {hi,lo} on the next edge
// DIV     | one restoring step per edge, 32 steps
// DIV_FIX | apply signs / divide-by-zero result, write hi/lo
module mips_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DIV_FIX} state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  // a_q holds the multiplicand or the original dividend; b_q holds the
  // multiplier or the (absolute) divisor.
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] quot_q, quot_d, rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        mul_signed_q, mul_signed_d;
  logic        qsign_q, qsign_d, rsign_q, rsign_d;
  logic        dz_q, dz_d;

  logic        signed_op;
  logic [31:0] abs_a, abs_b;
  logic [63:0] ext_a, ext_b, prod;
  logic [32:0] rem_shift;

  always_comb begin
    state_d      = state_q;
    done_d       = 1'b0;
    hi_d         = hi_q;
    lo_d         = lo_q;
    a_d          = a_q;
    b_d          = b_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    cnt_d        = cnt_q;
    mul_signed_d = mul_signed_q;
    qsign_d      = qsign_q;
    rsign_d      = rsign_q;
    dz_d         = dz_q;

    // Even opcodes of each pair are the signed variants.
    signed_op = ~op[0];
    abs_a     = (signed_op && operand_a[31]) ? -operand_a : operand_a;
    abs_b     = (signed_op && operand_b[31]) ? -operand_b : operand_b;

    // Low 64 bits of a 64x64 product of the extended operands give the
    // correct signed or unsigned 32x32 result.
    ext_a     = mul_signed_q ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    ext_b     = mul_signed_q ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod      = ext_a * ext_b;

    rem_shift = {rem_q, quot_q[31]};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (op)
            3'd4: hi_d = operand_a;
            3'd5: lo_d = operand_a;
            3'd0, 3'd1: begin
              a_d          = operand_a;
              b_d          = operand_b;
              mul_signed_d = signed_op;
              state_d      = MUL;
            end
            3'd2, 3'd3: begin
              a_d     = operand_a;
              b_d     = abs_b;
              quot_d  = abs_a;
              rem_d   = 32'd0;
              cnt_d   = 6'd32;
              qsign_d = signed_op & (operand_a[31] ^ operand_b[31]);
              rsign_d = signed_op & operand_a[31];
              dz_d    = (operand_b == 32'd0);
              state_d = DIV;
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        {hi_d, lo_d} = prod;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      DIV: begin
        if (rem_shift >= {1'b0, b_q}) begin
          rem_d  = 32'(rem_shift - {1'b0, b_q});
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = rem_shift[31:0];
          quot_d = {quot_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = DIV_FIX;
      end
      DIV_FIX: begin
        if (dz_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = a_q;
        end else begin
          lo_d = qsign_q ? -quot_q : quot_q;
          hi_d = rsign_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      quot_q       <= 32'd0;
      rem_q        <= 32'd0;
      cnt_q        <= 6'd0;
      mul_signed_q <= 1'b0;
      qsign_q      <= 1'b0;
      rsign_q      <= 1'b0;
      dz_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      a_q          <= a_d;
      b_q          <= b_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      mul_signed_q <= mul_signed_d;
      qsign_q      <= qsign_d;
      rsign_q      <= rsign_d;
      dz_q         <= dz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
